// File: rtl/i2c_mem_arbiter.sv
// Two-port arbiter in front of one single-port, synchronous-read register memory.
// Port A (I2C path) has priority; a bounded-wait counter guarantees port B progress.
module i2c_mem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
   typedef enum logic {OWN_A, OWN_B} owner_t;

   state_t          state_q,    state_d;
   owner_t          owner_q,    owner_d;
   logic            we_q,       we_d;
   logic [AW-1:0]   addr_q,     addr_d;
   logic [DW-1:0]   wdata_q,    wdata_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [LW-1:0]   lat_cnt_q,  lat_cnt_d;
   logic [DW-1:0]   a_rdata_q,  a_rdata_d;
   logic [DW-1:0]   b_rdata_q,  b_rdata_d;
   logic            pick_b;

   // B wins when alone, or when it has already lost MAX_WAIT arbitrations in a row.
   assign pick_b = b_req && (!a_req || (wait_cnt_q == WW'(MAX_WAIT)));

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         owner_q    <= OWN_A;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt_q <= '0;
         lat_cnt_q  <= '0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               state_d = S_ACCESS;
               if (pick_b) begin
                  owner_d    = OWN_B;
                  we_d       = b_we;
                  addr_d     = b_addr;
                  wdata_d    = b_wdata;
                  wait_cnt_d = '0;
               end else begin
                  owner_d = OWN_A;
                  we_d    = a_we;
                  addr_d  = a_addr;
                  wdata_d = a_wdata;
                  if (b_req && (wait_cnt_q != WW'(MAX_WAIT))) begin
                     wait_cnt_d = wait_cnt_q + WW'(1);
                  end
               end
            end
         end
         S_ACCESS: begin
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               lat_cnt_d = LW'(MEM_LAT - 1);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_cnt_q == '0) begin
               if (owner_q == OWN_A) a_rdata_d = mem_rdata;
               else                  b_rdata_d = mem_rdata;
               state_d = S_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - LW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode the registered state; mem_* read as zero outside the access cycle.
   always_comb begin
      mem_en    = (state_q == S_ACCESS);
      mem_we    = mem_en && we_q;
      mem_addr  = mem_en ? addr_q  : '0;
      mem_wdata = mem_en ? wdata_q : '0;
      a_gnt     = mem_en && (owner_q == OWN_A);
      b_gnt     = mem_en && (owner_q == OWN_B);
      a_rvalid  = (state_q == S_RESP) && (owner_q == OWN_A);
      b_rvalid  = (state_q == S_RESP) && (owner_q == OWN_B);
      a_rdata   = a_rdata_q;
      b_rdata   = b_rdata_q;
      busy      = (state_q != S_IDLE);
   end

endmodule
